aes128_encrypt_core: RTL and testbench
======================================

// Module: aes128_encrypt_core
// PURPOSE
//   Iterative AES-128 encryptor (FIPS-197): one round per clock, on-the-fly forward key expansion.
//   Pairs with the decryption top: its ciphertext feeds that block directly.
//   final_key exports round key 10, the start point for inverse key expansion.
//   Encrypts one 128-bit block per start; result and done go to the consumer.
// PARAMETERS
//   DONE_PULSE   1    1: done is a one-cycle pulse; 0: done held high until next accepted start
//   ROUNDS       10   number of rounds; only 10 is legal (AES-128); other values are a config error
// PORTS
//   clk          in   1    rising-edge clock
//   reset_n      in   1    asynchronous active-low reset
//   start        in   1    request; sampled only while busy=0
//   plaintext    in   128  input block; [127:120] = state byte 0 (FIPS column-major order)
//   key          in   128  cipher key; same byte order
//   ciphertext   out  128  result block, registered
//   final_key    out  128  round key 10, registered, valid with done
//   busy         out  1    high from cycle after accepted start until result cycle
//   done         out  1    result valid strobe (see DONE_PULSE)
// BEHAVIOUR
//   Reset: ciphertext=0, final_key=0, busy=0, done=0, FSM=IDLE, round=0, rcon=8'h01. Async assert.
//   FSM: IDLE -> RUN -> IDLE. Result is registered on the last RUN edge, so there is no separate DONE state.
//   IDLE: on a clk edge with start=1:
//     - state <= plaintext ^ key; rk <= key
//     - round <= 1; rcon <= 8'h01; busy <= 1
//     - done <= 0 (both DONE_PULSE modes)
//     - plaintext/key are sampled only on this edge and may change afterwards.
//   RUN, round r = 1..9, each edge:
//     - rk <= expand(rk, rcon); rcon <= xtime(rcon)
//     - state <= MixColumns(ShiftRows(SubBytes(state))) ^ expand(rk, rcon); round <= r+1
//   RUN, round 10 edge:
//     - ciphertext <= ShiftRows(SubBytes(state)) ^ expand(rk, rcon); final_key <= expand(rk, rcon)
//     - done <= 1; busy <= 0; FSM -> IDLE.
//   expand(w, c): t = SubWord(RotWord(w[31:0])) ^ {c, 24'h0}
//     w0' = w[127:96]^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
//   xtime: {c[6:0],1'b0} ^ (c[7] ? 8'h1b : 0). rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
//   Latency: done high exactly 10 cycles after the start-sampling edge. Throughput: one block per 11 cycles min.
//   done, DONE_PULSE=1: high one cycle, then cleared.
//   done, DONE_PULSE=0: stays high until the next accepted start edge clears it.
//   start while busy=1: ignored, no effect on state or outputs.
//   start in the cycle done is high: accepted, because busy=0 in that cycle.
//     - New run starts; ciphertext/final_key keep old values until the new round-10 edge.
//   start held high continuously: back-to-back blocks, one every 11 cycles.
//   reset_n low mid-run: run aborted, all outputs at reset values; no done for the aborted block.
//   S-box: combinational forward table, 16 instances for the state plus 4 for the key.
//     - Single-cycle round path; no multicycle constraints.
//   Internal state/rk/round are not visible; outputs only change on round-10 edge or reset.
// TESTING
//   1 FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734
//       -> ct=3925841d02dc09fbdc118597196a0b32, final_key=d014f9a8c9ee2589e13f0cc8b6630ca6, done at +10.
//   2 FIPS-197 App.C.1: key=000102..0f, pt=00112233445566778899aabbccddeeff
//       -> ct=69c4e0d86a7b0430d8cdb78070b4c55a, final_key=13111d7fe3944a17f307a78b4d2b30c5.
//   3 Start re-pulsed at cycles +3 and +7 with different pt -> ignored.
//       -> Test-1 result unchanged; exactly one done.
//   4 start held high with vectors 1 then 2 -> dones at +10 and +21; correct ct each.
//       -> ciphertext holds old value between dones.
//   5 reset_n low at cycle +5 -> outputs 0, busy=0 immediately (async).
//       -> After release, test 2 passes with normal latency.
//   6 Loopback: ct and final_key fed to the decryption top -> original plaintext recovered.
//       -> Repeat for both DONE_PULSE settings; check done width (1 cycle vs held until next start).

Source files
------------

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion; done 10 cycles after start.
// No backpressure: start is only sampled while idle, and the result registers hold until the next round-10 edge.
module aes128_encrypt_core #(
   parameter bit DONE_PULSE = 1'b1,
   parameter int ROUNDS     = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic [127:0] ciphertext,
   output logic [127:0] final_key,
   output logic         busy,
   output logic         done
);

   generate
      if (ROUNDS != 10) begin : g_cfg_err
         $error("aes128_encrypt_core: ROUNDS must be 10 for AES-128");
      end
   endgenerate

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   // Forward S-box, entry 0 in the top byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {IDLE, RUN} fsm_t;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] byte_of(input logic [127:0] v, input int idx);
      return v[127-8*idx -: 8];
   endfunction

   fsm_t         fsm_q;
   logic [127:0] state_q;
   logic [127:0] rk_q;
   logic [7:0]   rcon_q;
   logic [3:0]   round_q;

   logic [127:0] sr_sb;
   logic [127:0] mix_cols;
   logic [31:0]  sub_rot;
   logic [31:0]  w0_next, w1_next, w2_next, w3_next;
   logic [127:0] rk_next;

   // Byte n = 4*col + row; ShiftRows pulls row r from column (col + r) mod 4.
   always_comb begin
      sr_sb = '0;
      for (int n = 0; n < 16; n++) begin
         sr_sb[127-8*n -: 8] =
            sbox(byte_of(state_q, 4*(((n >> 2) + (n & 3)) & 3) + (n & 3)));
      end
   end

   always_comb begin
      mix_cols = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            mix_cols[127-8*(4*c+r) -: 8] =
                 xtime(byte_of(sr_sb, 4*c + r))
               ^ xtime(byte_of(sr_sb, 4*c + ((r+1) & 3)))
               ^ byte_of(sr_sb, 4*c + ((r+1) & 3))
               ^ byte_of(sr_sb, 4*c + ((r+2) & 3))
               ^ byte_of(sr_sb, 4*c + ((r+3) & 3));
         end
      end
   end

   assign sub_rot = {sbox(rk_q[23:16]) ^ rcon_q, sbox(rk_q[15:8]),
                     sbox(rk_q[7:0]), sbox(rk_q[31:24])};
   assign w0_next = rk_q[127:96] ^ sub_rot;
   assign w1_next = rk_q[95:64]  ^ w0_next;
   assign w2_next = rk_q[63:32]  ^ w1_next;
   assign w3_next = rk_q[31:0]   ^ w2_next;
   assign rk_next = {w0_next, w1_next, w2_next, w3_next};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q      <= IDLE;
         state_q    <= '0;
         rk_q       <= '0;
         rcon_q     <= 8'h01;
         round_q    <= '0;
         ciphertext <= '0;
         final_key  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (DONE_PULSE) done <= 1'b0;
               if (start) begin
                  state_q <= plaintext ^ key;
                  rk_q    <= key;
                  round_q <= 4'd1;
                  rcon_q  <= 8'h01;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  fsm_q   <= RUN;
               end
            end
            RUN: begin
               rk_q    <= rk_next;
               rcon_q  <= xtime(rcon_q);
               round_q <= round_q + 4'd1;
               if (round_q == LAST_ROUND) begin
                  // Final round skips MixColumns and lands straight in the output registers.
                  ciphertext <= sr_sb ^ rk_next;
                  final_key  <= rk_next;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  fsm_q      <= IDLE;
               end else begin
                  state_q <= mix_cols ^ rk_next;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Bench for aes128_encrypt_core: FIPS-197 vectors plus random blocks against a GF(2^8) reference model.
// Both done modes run side by side; a model inverse cipher closes the loop from ciphertext and final_key.
module tb_aes128_encrypt_core;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start;
   logic [127:0] pt_i, key_i;
   logic [127:0] ct_p, fk_p, ct_h, fk_h;
   logic         busy_p, done_p, busy_h, done_h;

   always #5 clk = ~clk;

   aes128_encrypt_core #(.DONE_PULSE(1'b1), .ROUNDS(10)) dut_p (
      .clk(clk), .reset_n(reset_n), .start(start), .plaintext(pt_i), .key(key_i),
      .ciphertext(ct_p), .final_key(fk_p), .busy(busy_p), .done(done_p));

   aes128_encrypt_core #(.DONE_PULSE(1'b0), .ROUNDS(10)) dut_h (
      .clk(clk), .reset_n(reset_n), .start(start), .plaintext(pt_i), .key(key_i),
      .ciphertext(ct_h), .final_key(fk_h), .busy(busy_h), .done(done_h));

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      logic [127:0] fk;
   } vec_t;

   vec_t       vecs [8];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse then the affine map.
   task automatic build_tables();
      logic [7:0] v, r, s, t;
      for (int x = 0; x < 256; x++) begin
         v = 8'(x);
         r = 8'h01;
         if (v == 8'h00) r = 8'h00;
         else for (int k = 0; k < 254; k++) r = gmul(r, v);
         s = r; t = r;
         for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
         end
         s = s ^ 8'h63;
         sb[x]  = s;
         isb[s] = v;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input int k);
      logic [7:0] rc;
      rc = 8'h01;
      for (int i = 1; i < k; i++) rc = xt(rc);
      return rc;
   endfunction

   task automatic aes_enc(input logic [127:0] k, input logic [127:0] p,
                          output logic [127:0] c, output logic [127:0] fk);
      logic [31:0] w [44];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [7:0]  a [4];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_of(i/4), 24'h0};
         w[i] = w[i-4] ^ tmp;
      end
      for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
         for (int cc = 0; cc < 4; cc++)
            for (int r = 0; r < 4; r++) t[4*cc+r] = s[4*((cc+r)%4)+r];
         if (rd < 10) begin
            for (int cc = 0; cc < 4; cc++) begin
               for (int r = 0; r < 4; r++) a[r] = t[4*cc+r];
               for (int r = 0; r < 4; r++)
                  t[4*cc+r] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
         end
         for (int n = 0; n < 16; n++) s[n] = t[n] ^ w[4*rd+n/4][31-8*(n%4) -: 8];
      end
      for (int n = 0; n < 16; n++) c[127-8*n -: 8] = s[n];
      fk = {w[40], w[41], w[42], w[43]};
   endtask

   // Inverse cipher driven only by the last round key, as the decryption side would be.
   task automatic aes_dec(input logic [127:0] c, input logic [127:0] fk, output logic [127:0] p);
      logic [31:0] w [44];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [7:0]  a [4];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[40+i] = fk[127-32*i -: 32];
      for (int i = 43; i >= 4; i--) begin
         tmp = w[i-1];
         if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_of(i/4), 24'h0};
         w[i-4] = w[i] ^ tmp;
      end
      for (int n = 0; n < 16; n++) s[n] = c[127-8*n -: 8] ^ w[40+n/4][31-8*(n%4) -: 8];
      for (int rd = 9; rd >= 0; rd--) begin
         for (int cc = 0; cc < 4; cc++)
            for (int r = 0; r < 4; r++) t[4*cc+r] = s[4*((cc+4-r)%4)+r];
         for (int n = 0; n < 16; n++) s[n] = isb[t[n]] ^ w[4*rd+n/4][31-8*(n%4) -: 8];
         if (rd > 0) begin
            for (int cc = 0; cc < 4; cc++) begin
               for (int r = 0; r < 4; r++) a[r] = s[4*cc+r];
               for (int r = 0; r < 4; r++)
                  s[4*cc+r] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b)
                            ^ gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
            end
         end
      end
      for (int n = 0; n < 16; n++) p[127-8*n -: 8] = s[n];
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic start_block(input logic [127:0] k, input logic [127:0] p);
      @(posedge clk); #1;
      start = 1'b1; key_i = k; pt_i = p;
      @(posedge clk); #1;
      start = 1'b0; key_i = rnd128(); pt_i = rnd128();
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (done_p) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           lat, dones, done_at;
      logic [127:0] rec;

      build_tables();
      reset_n = 1'b0; start = 1'b0; pt_i = '0; key_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ct",   ct_p, 128'h0);
      chk("reset_fk",   fk_p, 128'h0);
      chk("reset_busy", 128'(busy_p), 128'h0);
      chk("reset_done", 128'({done_p, done_h}), 128'h0);
      @(negedge clk) reset_n = 1'b1;

      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
      for (int i = 2; i < 8; i++) begin
         vecs[i].key = rnd128();
         vecs[i].pt  = rnd128();
         aes_enc(vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].fk);
      end

      // Table of blocks: latency, result, loopback and done width for both modes.
      for (int v = 0; v < 8; v++) begin
         start_block(vecs[v].key, vecs[v].pt);
         chk("busy_after_start", 128'(busy_p), 128'h1);
         chk("done_held_cleared_by_start", 128'(done_h), 128'h0);
         wait_done(lat);
         chk("latency", 128'(lat), 128'd10);
         chk("ciphertext", ct_p, vecs[v].ct);
         chk("final_key", fk_p, vecs[v].fk);
         chk("ciphertext_held_mode", ct_h, vecs[v].ct);
         chk("final_key_held_mode", fk_h, vecs[v].fk);
         chk("busy_at_done", 128'(busy_p), 128'h0);
         chk("done_held_mode_rise", 128'(done_h), 128'h1);
         aes_dec(ct_p, fk_p, rec);
         chk("loopback_plaintext", rec, vecs[v].pt);
         @(posedge clk); #1;
         chk("done_pulse_width", 128'(done_p), 128'h0);
         chk("done_held_width", 128'(done_h), 128'h1);
      end

      // start re-pulsed while busy must be ignored.
      start_block(vecs[0].key, vecs[0].pt);
      dones = 0; done_at = 0;
      for (int n = 1; n <= 24; n++) begin
         start = (n == 3 || n == 7);
         pt_i = rnd128(); key_i = rnd128();
         @(posedge clk); #1;
         start = 1'b0;
         if (done_p) begin
            dones++;
            if (done_at == 0) done_at = n;
         end
      end
      chk("repulse_done_count", 128'(dones), 128'd1);
      chk("repulse_done_cycle", 128'(done_at), 128'd10);
      chk("repulse_ciphertext", ct_p, vecs[0].ct);

      // start held high: back-to-back blocks 11 cycles apart.
      @(posedge clk); #1;
      start = 1'b1; key_i = vecs[0].key; pt_i = vecs[0].pt;
      @(posedge clk); #1;
      key_i = vecs[1].key; pt_i = vecs[1].pt;
      for (int n = 1; n <= 22; n++) begin
         @(posedge clk); #1;
         if (n == 10) begin
            chk("b2b_done1", 128'(done_p), 128'h1);
            chk("b2b_ct1", ct_p, vecs[0].ct);
         end
         if (n == 11) begin
            chk("b2b_restart_busy", 128'(busy_p), 128'h1);
            chk("b2b_held_done_cleared", 128'(done_h), 128'h0);
         end
         if (n == 16) chk("b2b_ct_hold", ct_p, vecs[0].ct);
         if (n == 21) begin
            chk("b2b_done2", 128'(done_p), 128'h1);
            chk("b2b_ct2", ct_p, vecs[1].ct);
            chk("b2b_fk2", fk_p, vecs[1].fk);
            start = 1'b0;
         end
         if (n == 22) chk("b2b_idle_after", 128'(busy_p), 128'h0);
      end

      // Asynchronous reset in the middle of a run.
      start_block(vecs[0].key, vecs[0].pt);
      repeat (5) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("midrun_reset_ct", ct_p, 128'h0);
      chk("midrun_reset_fk", fk_p, 128'h0);
      chk("midrun_reset_busy", 128'({busy_p, busy_h}), 128'h0);
      chk("midrun_reset_done", 128'({done_p, done_h}), 128'h0);
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk); #1;
         if (done_p || busy_p) dones++;
      end
      chk("aborted_block_silent", 128'(dones), 128'h0);
      start_block(vecs[1].key, vecs[1].pt);
      wait_done(lat);
      chk("post_reset_latency", 128'(lat), 128'd10);
      chk("post_reset_ct", ct_p, vecs[1].ct);
      chk("post_reset_fk", fk_p, vecs[1].fk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
